bsk_ntw_cmd_arbiter_rr: RTL and testbench

// Parametrised batch-command arbiter for the BSK network. Merges commands from CLT_NB clients

---
 rtl/bsk_ntw_cmd_arbiter_rr.sv | 238 +++++++++++++++++++++++
 tb/tb_bsk_ntw_cmd_arbiter_rr.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bsk_ntw_cmd_arbiter_rr.sv
// bsk_ntw_cmd_arbiter_rr
//   Round-robin batch-command arbiter for the BSK network. Accepts at most one
//   client command per cycle, drops commands whose key already waits in the
//   pending pool, and broadcasts the pool in strict age order to all servers.
//   Issue is limited by credits equal to the server command FIFO depth; a
//   credit returns after DIST_ITER_NB srv_bdc_avail pulses.
// Ports
//   clk, s_rst_n    clock, synchronous active-low reset
//   clt_cmd/vld/rdy per-client command handshake (rdy is one-hot or zero)
//   srv_cmd         registered broadcast command, valid with srv_cmd_avail
//   srv_bdc_avail   server broadcast-done pulse (credit return counting)
//   flush           empties the pending pool at the next edge
//   pool_cnt        occupied pool entries
//   infl_cnt        issued, not yet retired commands
//   merge_cnt       saturating count of dropped duplicates

module bsk_ntw_cmd_arbiter_rr_chk #(
  parameter int CLT_NB = 3,
  parameter int CMD_W  = 16,
  parameter int ICNT_W = 3
) (
  input logic                    clk,
  input logic                    s_rst_n,
  input logic [CLT_NB*CMD_W-1:0] clt_cmd,
  input logic [CLT_NB-1:0]       clt_vld,
  input logic [CLT_NB-1:0]       clt_rdy,
  input logic                    retire,
  input logic [ICNT_W-1:0]       infl_cnt
);

  a_retire_empty: assert property (@(posedge clk) disable iff (!s_rst_n)
    !(retire && (infl_cnt == '0)))
    else $fatal(1, "retirement with no command in flight");

  a_rdy_onehot: assert property (@(posedge clk) $onehot0(clt_rdy))
    else $fatal(1, "clt_rdy not one-hot-or-zero");

  a_clt_known: assert property (@(posedge clk) disable iff (!s_rst_n)
    !$isunknown({clt_cmd, clt_vld}))
    else $fatal(1, "client inputs unknown out of reset");

endmodule

module bsk_ntw_cmd_arbiter_rr #(
  parameter int CLT_NB         = 3,
  parameter int CMD_W          = 16,
  parameter int KEY_LSB        = 0,
  parameter int KEY_W          = 8,
  parameter int POOL_DEPTH     = 8,
  parameter int SRV_FIFO_DEPTH = 4,
  parameter int DIST_ITER_NB   = 8
) (
  input  logic                                  clk,
  input  logic                                  s_rst_n,
  input  logic [CLT_NB*CMD_W-1:0]               clt_cmd,
  input  logic [CLT_NB-1:0]                     clt_vld,
  output logic [CLT_NB-1:0]                     clt_rdy,
  output logic [CMD_W-1:0]                      srv_cmd,
  output logic                                  srv_cmd_avail,
  input  logic                                  srv_bdc_avail,
  input  logic                                  flush,
  output logic [$clog2(POOL_DEPTH+1)-1:0]       pool_cnt,
  output logic [$clog2(SRV_FIFO_DEPTH+1)-1:0]   infl_cnt,
  output logic [15:0]                           merge_cnt
);

  localparam int PTR_W  = (CLT_NB > 1) ? $clog2(CLT_NB) : 1;
  localparam int PCNT_W = $clog2(POOL_DEPTH + 1);
  localparam int ICNT_W = $clog2(SRV_FIFO_DEPTH + 1);
  localparam int ITER_W = (DIST_ITER_NB > 1) ? $clog2(DIST_ITER_NB) : 1;

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(CLT_NB - 1);
  localparam logic [PCNT_W-1:0] POOL_FULL = PCNT_W'(POOL_DEPTH);
  localparam logic [ICNT_W-1:0] INFL_FULL = ICNT_W'(SRV_FIFO_DEPTH);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DIST_ITER_NB - 1);

  logic [PTR_W-1:0]  rr_ptr_r;
  logic [CMD_W-1:0]  pool_r [POOL_DEPTH];
  logic [PCNT_W-1:0] pool_cnt_r;
  logic [ICNT_W-1:0] infl_cnt_r;
  logic [ITER_W-1:0] iter_cnt_r;
  logic [15:0]       merge_cnt_r;
  logic [CMD_W-1:0]  srv_cmd_r;
  logic              srv_cmd_avail_r;

  logic              hi_vld_s, lo_vld_s, grant_vld_s;
  logic [PTR_W-1:0]  hi_idx_s, lo_idx_s, grant_idx_s;
  logic              accept_s, dup_s, append_s, merge_s, issue_s, retire_s;
  logic [CLT_NB-1:0] clt_rdy_s;
  logic [CMD_W-1:0]  acc_cmd_s;
  logic [CMD_W-1:0]  pool_nxt_s [POOL_DEPTH];
  logic [PCNT_W-1:0] wr_pos_s;
  logic [PCNT_W-1:0] pool_cnt_nxt_s;
  logic [ICNT_W-1:0] infl_cnt_nxt_s;

  // Round-robin grant: lowest valid index at/above rr_ptr, else lowest overall (wrap).
  always_comb begin
    hi_vld_s = 1'b0;
    hi_idx_s = '0;
    lo_vld_s = 1'b0;
    lo_idx_s = '0;
    for (int j = 0; j < CLT_NB; j++) begin
      if (!hi_vld_s && clt_vld[j] && (PTR_W'(j) >= rr_ptr_r)) begin
        hi_vld_s = 1'b1;
        hi_idx_s = PTR_W'(j);
      end else begin
        hi_vld_s = hi_vld_s;
      end
      if (!lo_vld_s && clt_vld[j]) begin
        lo_vld_s = 1'b1;
        lo_idx_s = PTR_W'(j);
      end else begin
        lo_vld_s = lo_vld_s;
      end
    end
    grant_vld_s = hi_vld_s | lo_vld_s;
    grant_idx_s = hi_vld_s ? hi_idx_s : lo_idx_s;
  end

  // Accept, ready vector, granted command and dedup lookup against the registered pool.
  always_comb begin
    accept_s  = grant_vld_s && s_rst_n && (pool_cnt_r < POOL_FULL) && !flush;
    clt_rdy_s = '0;
    acc_cmd_s = '0;
    dup_s     = 1'b0;
    for (int j = 0; j < CLT_NB; j++) begin
      if (grant_idx_s == PTR_W'(j)) begin
        clt_rdy_s[j] = accept_s;
        acc_cmd_s    = clt_cmd[j*CMD_W +: CMD_W];
      end else begin
        clt_rdy_s[j] = 1'b0;
      end
    end
    for (int j = 0; j < POOL_DEPTH; j++) begin
      if ((PCNT_W'(j) < pool_cnt_r) &&
          (pool_r[j][KEY_LSB +: KEY_W] == acc_cmd_s[KEY_LSB +: KEY_W])) begin
        dup_s = 1'b1;
      end else begin
        dup_s = dup_s;
      end
    end
    append_s = accept_s && !dup_s;
    merge_s  = accept_s && dup_s;
    // Issue decisions use registered counts only, so a freed credit is usable next cycle.
    issue_s  = (pool_cnt_r != '0) && (infl_cnt_r < INFL_FULL) && !flush;
    retire_s = srv_bdc_avail && (iter_cnt_r == ITER_LAST);
  end

  // Pool next state: pop the head on issue (shift), then append behind the survivors.
  always_comb begin
    pool_nxt_s = pool_r;
    wr_pos_s   = pool_cnt_r;
    if (issue_s) begin
      for (int j = 0; j < POOL_DEPTH - 1; j++) begin
        pool_nxt_s[j] = pool_r[j+1];
      end
      wr_pos_s = pool_cnt_r - PCNT_W'(1);
    end else begin
      wr_pos_s = pool_cnt_r;
    end
    for (int j = 0; j < POOL_DEPTH; j++) begin
      if (append_s && (PCNT_W'(j) == wr_pos_s)) begin
        pool_nxt_s[j] = acc_cmd_s;
      end else begin
        pool_nxt_s[j] = pool_nxt_s[j];
      end
    end
    if (flush) begin
      pool_cnt_nxt_s = '0;
    end else begin
      case ({append_s, issue_s})
        2'b10:   pool_cnt_nxt_s = pool_cnt_r + PCNT_W'(1);
        2'b01:   pool_cnt_nxt_s = pool_cnt_r - PCNT_W'(1);
        default: pool_cnt_nxt_s = pool_cnt_r;
      endcase
    end
    case ({issue_s, retire_s})
      2'b10:   infl_cnt_nxt_s = infl_cnt_r + ICNT_W'(1);
      2'b01:   infl_cnt_nxt_s = infl_cnt_r - ICNT_W'(1);
      default: infl_cnt_nxt_s = infl_cnt_r;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      rr_ptr_r        <= '0;
      pool_cnt_r      <= '0;
      infl_cnt_r      <= '0;
      iter_cnt_r      <= '0;
      merge_cnt_r     <= 16'd0;
      srv_cmd_r       <= '0;
      srv_cmd_avail_r <= 1'b0;
      for (int j = 0; j < POOL_DEPTH; j++) begin
        pool_r[j] <= '0;
      end
    end else begin
      pool_r          <= pool_nxt_s;
      pool_cnt_r      <= pool_cnt_nxt_s;
      infl_cnt_r      <= infl_cnt_nxt_s;
      srv_cmd_avail_r <= issue_s;
      if (issue_s) begin
        srv_cmd_r <= pool_r[0];
      end
      if (accept_s) begin
        rr_ptr_r <= (grant_idx_s == PTR_LAST) ? '0 : grant_idx_s + PTR_W'(1);
      end
      if (srv_bdc_avail) begin
        iter_cnt_r <= retire_s ? '0 : iter_cnt_r + ITER_W'(1);
      end
      if (merge_s && (merge_cnt_r != 16'hFFFF)) begin
        merge_cnt_r <= merge_cnt_r + 16'd1;
      end
    end
  end

  assign clt_rdy       = clt_rdy_s;
  assign srv_cmd       = srv_cmd_r;
  assign srv_cmd_avail = srv_cmd_avail_r;
  assign pool_cnt      = pool_cnt_r;
  assign infl_cnt      = infl_cnt_r;
  assign merge_cnt     = merge_cnt_r;

  bsk_ntw_cmd_arbiter_rr_chk #(
    .CLT_NB (CLT_NB),
    .CMD_W  (CMD_W),
    .ICNT_W (ICNT_W)
  ) u_chk (
    .clk      (clk),
    .s_rst_n  (s_rst_n),
    .clt_cmd  (clt_cmd),
    .clt_vld  (clt_vld),
    .clt_rdy  (clt_rdy_s),
    .retire   (retire_s),
    .infl_cnt (infl_cnt_r)
  );

endmodule

// File: tb/tb_bsk_ntw_cmd_arbiter_rr.sv
// Bench for bsk_ntw_cmd_arbiter_rr with default parameters. A cycle model
// predicts ready, pool/credit counters and issue; issued commands are queued
// on the scoreboard and popped when the DUT raises srv_cmd_avail.
module tb_bsk_ntw_cmd_arbiter_rr;

  logic        clk = 1'b0;
  logic        s_rst_n = 1'b0;
  logic [47:0] clt_cmd = 48'd0;
  logic [2:0]  clt_vld = 3'd0;
  logic [2:0]  clt_rdy;
  logic [15:0] srv_cmd;
  logic        srv_cmd_avail;
  logic        srv_bdc_avail = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  pool_cnt;
  logic [2:0]  infl_cnt;
  logic [15:0] merge_cnt;

  bsk_ntw_cmd_arbiter_rr dut (
    .clk           (clk),
    .s_rst_n       (s_rst_n),
    .clt_cmd       (clt_cmd),
    .clt_vld       (clt_vld),
    .clt_rdy       (clt_rdy),
    .srv_cmd       (srv_cmd),
    .srv_cmd_avail (srv_cmd_avail),
    .srv_bdc_avail (srv_bdc_avail),
    .flush         (flush),
    .pool_cnt      (pool_cnt),
    .infl_cnt      (infl_cnt),
    .merge_cnt     (merge_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_pool[$];
  logic [15:0] exp_q[$];
  int          m_infl = 0, m_iter = 0, m_rr = 0, m_merge = 0;
  logic        m_avail = 1'b0;

  logic [15:0] cur_cmd[3];
  bit          have[3];
  int          next_key = 1, key_lim = 1, last_acc = -1;

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock: compare at negedge, predict, advance the model after posedge.
  task automatic step();
    bit          found, acc, iss, ret, match, rst_smp, fl, bdc;
    int          g;
    logic [2:0]  rdy_e;
    logic [15:0] acmd;
    @(negedge clk);
    rst_smp = s_rst_n;
    fl      = flush;
    bdc     = srv_bdc_avail;
    found   = 1'b0;
    g       = 0;
    for (int i = 0; i < 3; i++) begin
      int idx;
      idx = (m_rr + i) % 3;
      if (!found && clt_vld[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
    acc   = found && rst_smp && (m_pool.size() < 8) && !fl;
    rdy_e = acc ? 3'(1 << g) : 3'd0;
    chk_val("clt_rdy", 32'(clt_rdy), 32'(rdy_e));
    chk_val("srv_cmd_avail", 32'(srv_cmd_avail), 32'(m_avail));
    if (srv_cmd_avail) begin
      if (exp_q.size() == 0) chk_val("sb_nonempty", 32'(exp_q.size()), 32'd1);
      else chk_val("srv_cmd", 32'(srv_cmd), 32'(exp_q.pop_front()));
    end
    chk_val("pool_cnt", 32'(pool_cnt), 32'(m_pool.size()));
    chk_val("infl_cnt", 32'(infl_cnt), 32'(m_infl));
    chk_val("merge_cnt", 32'(merge_cnt), 32'(m_merge));
    iss  = (m_pool.size() > 0) && (m_infl < 4) && !fl;
    ret  = bdc && (m_iter == 7);
    acmd = clt_cmd[g*16 +: 16];
    match = 1'b0;
    foreach (m_pool[k]) if (m_pool[k][7:0] == acmd[7:0]) match = 1'b1;
    @(posedge clk);
    if (!rst_smp) begin
      m_pool.delete();
      exp_q.delete();
      m_infl = 0; m_iter = 0; m_rr = 0; m_merge = 0; m_avail = 1'b0;
      last_acc = -1;
    end else begin
      m_avail = iss;
      if (iss) exp_q.push_back(m_pool[0]);
      if (fl) m_pool.delete();
      else begin
        if (iss) void'(m_pool.pop_front());
        if (acc && !match) m_pool.push_back(acmd);
      end
      if (acc && match && m_merge < 65535) m_merge++;
      if (acc) m_rr = (g + 1) % 3;
      if (iss && !ret) m_infl++;
      else if (ret && !iss) m_infl--;
      if (bdc) m_iter = ret ? 0 : m_iter + 1;
      last_acc = acc ? g : -1;
    end
    #1;
  endtask

  task automatic run(input int n, input logic [2:0] feed, input bit bdc_en, input bit fl, input bit rst);
    for (int c = 0; c < n; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (feed[k] && !have[k] && next_key < key_lim) begin
          cur_cmd[k] = {8'($urandom_range(0, 255)), 8'(next_key)};
          next_key++;
          have[k] = 1'b1;
        end
      end
      s_rst_n       = !rst;
      flush         = fl;
      srv_bdc_avail = bdc_en && (m_infl > 0);
      clt_vld       = {have[2], have[1], have[0]};
      clt_cmd       = {cur_cmd[2], cur_cmd[1], cur_cmd[0]};
      step();
      if (last_acc >= 0) have[last_acc] = 1'b0;
    end
    flush         = 1'b0;
    srv_bdc_avail = 1'b0;
    s_rst_n       = 1'b1;
  endtask

  task automatic drain();
    int c = 0;
    while ((m_pool.size() > 0 || m_infl > 0 || have[0] || have[1] || have[2]) && c < 800) begin
      run(1, 3'b000, 1'b1, 1'b0, 1'b0);
      c++;
    end
    chk_val("drain_done", 32'(m_pool.size() + m_infl), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      cur_cmd[k] = 16'd0;
      have[k]    = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    run(3, 3'b000, 1'b0, 1'b0, 1'b1);
    chk_val("rst_srv_cmd", 32'(srv_cmd), 32'd0);

    // T1: all clients valid, keys 1..9.
    key_lim = 10;
    run(14, 3'b111, 1'b1, 1'b0, 1'b0);
    drain();

    // T2: same key from clients 0 and 2.
    cur_cmd[0] = 16'hA005;
    cur_cmd[2] = 16'hB205;
    have[0] = 1'b1;
    have[2] = 1'b1;
    run(4, 3'b000, 1'b0, 1'b0, 1'b0);
    drain();
    chk_val("t2_merge", 32'(merge_cnt), 32'd1);

    // T3: credit limit, then one retirement.
    next_key = 20;
    key_lim  = 26;
    run(12, 3'b010, 1'b0, 1'b0, 1'b0);
    chk_val("t3_infl_full", 32'(infl_cnt), 32'd4);
    chk_val("t3_pool", 32'(pool_cnt), 32'd2);
    run(8, 3'b000, 1'b1, 1'b0, 1'b0);
    run(3, 3'b000, 1'b0, 1'b0, 1'b0);
    chk_val("t3_infl_reissue", 32'(infl_cnt), 32'd4);
    chk_val("t3_pool_after", 32'(pool_cnt), 32'd1);

    // T4: fill pool with no credits, then free one credit.
    key_lim = 60;
    run(14, 3'b111, 1'b0, 1'b0, 1'b0);
    chk_val("t4_pool_full", 32'(pool_cnt), 32'd8);
    chk_val("t4_rdy_blocked", 32'(clt_rdy), 32'd0);
    run(8, 3'b111, 1'b1, 1'b0, 1'b0);
    run(4, 3'b111, 1'b0, 1'b0, 1'b0);

    // T5: flush with a busy pool and credits in flight.
    run(16, 3'b000, 1'b1, 1'b0, 1'b0);
    run(1, 3'b111, 1'b0, 1'b1, 1'b0);
    chk_val("t5_pool_flushed", 32'(pool_cnt), 32'd0);
    chk_val("t5_no_issue", 32'(srv_cmd_avail), 32'd0);
    run(2, 3'b000, 1'b0, 1'b0, 1'b0);
    drain();

    // T6: one-cycle reset mid-stream.
    key_lim = next_key + 30;
    run(10, 3'b111, 1'b1, 1'b0, 1'b0);
    run(1, 3'b111, 1'b1, 1'b0, 1'b1);
    chk_val("t6_srv_cmd", 32'(srv_cmd), 32'd0);
    chk_val("t6_merge", 32'(merge_cnt), 32'd0);
    chk_val("t6_infl", 32'(infl_cnt), 32'd0);
    run(20, 3'b111, 1'b1, 1'b0, 1'b0);
    drain();

    chk_val("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
